// File: rtl/accum_sum_if.sv
`default_nettype none
// ============================================================================
// Module   : accum_sum_if
// Purpose  : Handshake and data bundle for accum_sum. Carries the operand
//            side (valid/ready, operands, mode, clear) and the result side
//            (valid/ready, sum, overflow).
// Revision : 1.0 - initial release
// ============================================================================
interface accum_sum_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
);
    // Operand side
    logic                         IN_valid;
    logic                         OUT_ready;
    logic [CHANNELS*WIDTH-1:0]    IN_operands;
    logic                         IN_mode;
    logic                         IN_clear;

    // Result side
    logic                         OUT_valid;
    logic                         IN_ready;
    logic [WIDTH-1:0]             OUT_sum;
    logic                         OUT_overflow;

    // The adder itself
    modport slave (
        input  IN_valid,
        input  IN_operands,
        input  IN_mode,
        input  IN_clear,
        input  IN_ready,
        output OUT_ready,
        output OUT_valid,
        output OUT_sum,
        output OUT_overflow
    );

    // Whoever drives operands and consumes results
    modport master (
        output IN_valid,
        output IN_operands,
        output IN_mode,
        output IN_clear,
        output IN_ready,
        input  OUT_ready,
        input  OUT_valid,
        input  OUT_sum,
        input  OUT_overflow
    );
endinterface
`default_nettype wire

// File: rtl/accum_sum.sv
`default_nettype none
// ============================================================================
// Module   : accum_sum
// Purpose  : Registered multi-operand adder with constant offset, optional
//            running accumulator, wrap/saturate result and valid/ready
//            handshake on both sides. Result appears one cycle after accept.
// Revision : 1.0 - initial release
// ============================================================================
module accum_sum #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter logic [63:0] OFFSET   = 64'd0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic        IN_clk,
    input  logic        IN_rstn,
    accum_sum_if.slave  bus
);
    // Wide enough for CHANNELS operands + offset + accumulator with no overflow
    localparam int unsigned SUM_W = WIDTH + $clog2(CHANNELS + 2);
    localparam int unsigned EXT_W = SUM_W - WIDTH;

    localparam logic [SUM_W-1:0] OFFSET_EXT = {{EXT_W{1'b0}}, OFFSET[WIDTH-1:0]};
    localparam logic [SUM_W-1:0] MAX_EXT    = {{EXT_W{1'b0}}, {WIDTH{1'b1}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_ovf_q;
    logic [WIDTH-1:0] acc_q;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic ready;
    logic accept;

    // The output slot frees up when empty or being drained this cycle
    assign ready  = !out_valid_q || bus.IN_ready;
    assign accept = bus.IN_valid && ready;

    // ------------------------------------------------------------------
    // Operand unpacking, each zero-extended to the full sum width
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] operand_ext [CHANNELS];

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        assign operand_ext[i] = {{EXT_W{1'b0}}, bus.IN_operands[i*WIDTH +: WIDTH]};
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [SUM_W-1:0] operand_total;
    logic [SUM_W-1:0] acc_term;
    logic [SUM_W-1:0] true_sum;
    logic             overflow;
    logic [WIDTH-1:0] result;

    // Sum of all operand channels
    always_comb begin
        operand_total = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            operand_total = operand_total + operand_ext[i];
        end
    end

    // Accumulator contributes only in accumulate mode; a simultaneous clear
    // means "clear, then add", so it contributes zero in that case
    always_comb begin
        acc_term = '0;
        if (bus.IN_mode && !bus.IN_clear) begin
            acc_term = {{EXT_W{1'b0}}, acc_q};
        end
    end

    assign true_sum = operand_total + OFFSET_EXT + acc_term;
    assign overflow = (true_sum > MAX_EXT);

    // Wrap keeps the low bits; saturate clamps to all-ones on overflow
    always_comb begin
        result = true_sum[WIDTH-1:0];
        if (SATURATE && overflow) begin
            result = {WIDTH{1'b1}};
        end
    end

    // ------------------------------------------------------------------
    // Accumulator next value
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] acc_next;

    // A standalone clear is honoured even while stalled by backpressure
    always_comb begin
        acc_next = acc_q;
        if (accept) begin
            if (bus.IN_mode) begin
                acc_next = result;
            end else if (bus.IN_clear) begin
                acc_next = '0;
            end
        end else if (bus.IN_clear) begin
            acc_next = '0;
        end
    end

    // Accumulator register
    always_ff @(posedge IN_clk or negedge IN_rstn) begin
        if (!IN_rstn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_next;
        end
    end

    // Output slot: load on accept, empty on drain without a new accept
    always_ff @(posedge IN_clk or negedge IN_rstn) begin
        if (!IN_rstn) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= result;
            out_ovf_q   <= overflow;
        end else if (bus.IN_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.OUT_ready    = ready;
    assign bus.OUT_valid    = out_valid_q;
    assign bus.OUT_sum      = out_sum_q;
    assign bus.OUT_overflow = out_ovf_q;

endmodule
`default_nettype wire
